alu_iter_divider: RTL and testbench

Multi-cycle integer divide/remainder unit for the pipeline EX stage, complementing the combinational shifter: where the shifter moves operands in one pass, this block performs 32 iterations of restoring shift-subtract division. It accepts a request from the EX stage, runs while the pipeline hazard unit stalls, and returns quotient or remainder with a one-cycle done pulse. It supports signed and unsigned division and remainder with RISC-V M-extension corner-case results.

---
 rtl/alu_iter_divider_pkg.sv | 63 ++++++
 rtl/alu_div_step.sv | 31 +++
 rtl/alu_iter_divider.sv | 190 +++++++++++++++++++
 tb/tb_alu_iter_divider.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_iter_divider_pkg.sv
// Shared opcodes, FSM state type and small arithmetic helpers for the
// iterative divide/remainder unit.
package alu_iter_divider_pkg;

    // Divide opcodes; chosen above the existing ALU codes so they never collide.
    localparam logic [3:0] OP_DIV  = 4'hA;
    localparam logic [3:0] OP_DIVU = 4'hB;
    localparam logic [3:0] OP_REM  = 4'hC;
    localparam logic [3:0] OP_REMU = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } div_state_e;

    // True for the four divide/remainder opcodes this block handles.
    function automatic logic op_is_valid(input logic [3:0] op);
        logic res;
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: res = 1'b1;
            default:                          res = 1'b0;
        endcase
        return res;
    endfunction

    // True for the signed flavours (DIV, REM).
    function automatic logic op_is_signed(input logic [3:0] op);
        logic res;
        case (op)
            OP_DIV, OP_REM: res = 1'b1;
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

    // True when the quotient is the requested result (DIV, DIVU).
    function automatic logic op_is_div(input logic [3:0] op);
        logic res;
        case (op)
            OP_DIV, OP_DIVU: res = 1'b1;
            default:         res = 1'b0;
        endcase
        return res;
    endfunction

    // Two's complement negation.
    function automatic logic [31:0] negate32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of v when it is to be read as negative; 0x80000000 maps to itself.
    function automatic logic [31:0] magnitude32(input logic [31:0] v, input logic neg);
        logic [31:0] res;
        if (neg) begin
            res = negate32(v);
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One combinational restoring shift-subtract step. Kept separate so an
// unrolled variant can chain several copies.
module alu_div_step
    import alu_iter_divider_pkg::*;
(
    input  logic [32:0] rem_in,
    input  logic        dividend_msb,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted_s;
    logic [32:0] divisor_ext_s;

    // Shift the next dividend bit in and subtract the divisor when it fits.
    always_comb begin
        shifted_s     = {rem_in[31:0], dividend_msb};
        divisor_ext_s = {1'b0, divisor};
        rem_out       = shifted_s;
        q_bit         = 1'b0;
        if (shifted_s >= divisor_ext_s) begin
            rem_out = shifted_s - divisor_ext_s;
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted_s;
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_iter_divider.sv
// Multi-cycle signed/unsigned divide and remainder unit for the EX stage.
// 32 restoring iterations, sign fixup in FIN, RISC-V M corner-case results.
module alu_iter_divider
    import alu_iter_divider_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic [XLEN-1:0] C,
    output logic            busy,
    output logic            done
);

    localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

    div_state_e state_r;
    div_state_e state_nxt_s;

    logic [3:0]      op_r;
    logic            sa_r;
    logic            sb_r;
    logic            zero_r;
    logic            bad_r;
    logic [XLEN-1:0] dvd_r;    // dividend on entry, quotient after the last step
    logic [XLEN-1:0] dvs_r;
    logic [32:0]     rem_r;
    logic [5:0]      cnt_r;

    logic [XLEN-1:0] c_r;
    logic            busy_r;
    logic            done_r;

    logic            accept_s;
    logic            finish_s;
    logic            req_signed_s;
    logic [32:0]     step_rem_s;
    logic            step_q_s;
    logic [XLEN-1:0] quot_s;
    logic [XLEN-1:0] remd_s;
    logic [XLEN-1:0] result_s;

    assign req_signed_s = op_is_signed(alu_op);

    alu_div_step u_step (
        .rem_in       (rem_r),
        .dividend_msb (dvd_r[XLEN-1]),
        .divisor      (dvs_r),
        .rem_out      (step_rem_s),
        .q_bit        (step_q_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush beats any pending start or completion.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    accept_s = 1'b1;
                    if (op_is_valid(alu_op) && (B != 32'd0)) begin
                        state_nxt_s = ST_CALC;
                    end else begin
                        state_nxt_s = ST_FIN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
                if (flush) begin
                    finish_s = 1'b0;
                end else begin
                    finish_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one restoring step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= 4'd0;
            sa_r   <= 1'b0;
            sb_r   <= 1'b0;
            zero_r <= 1'b0;
            bad_r  <= 1'b0;
            dvd_r  <= 32'd0;
            dvs_r  <= 32'd0;
            rem_r  <= 33'd0;
            cnt_r  <= 6'd0;
        end else if (accept_s) begin
            op_r   <= alu_op;
            sa_r   <= A[XLEN-1] & req_signed_s;
            sb_r   <= B[XLEN-1] & req_signed_s;
            zero_r <= (B == 32'd0);
            bad_r  <= ~op_is_valid(alu_op);
            dvd_r  <= magnitude32(A, A[XLEN-1] & req_signed_s);
            dvs_r  <= magnitude32(B, B[XLEN-1] & req_signed_s);
            rem_r  <= 33'd0;
            cnt_r  <= 6'd0;
        end else if (state_r == ST_CALC) begin
            rem_r  <= step_rem_s;
            dvd_r  <= {dvd_r[XLEN-2:0], step_q_s};
            cnt_r  <= cnt_r + 6'd1;
        end
    end

    // Sign fixup and result select, including divide-by-zero and bad-op results.
    always_comb begin
        quot_s   = dvd_r;
        remd_s   = rem_r[31:0];
        result_s = 32'd0;
        if (sa_r ^ sb_r) begin
            quot_s = negate32(dvd_r);
        end else begin
            quot_s = dvd_r;
        end
        if (sa_r) begin
            remd_s = negate32(rem_r[31:0]);
        end else begin
            remd_s = rem_r[31:0];
        end
        if (bad_r) begin
            result_s = 32'd0;
        end else if (zero_r) begin
            // dvd_r still holds |A|; restoring its sign gives back A.
            if (op_is_div(op_r)) begin
                result_s = 32'hFFFF_FFFF;
            end else begin
                result_s = magnitude32(dvd_r, sa_r);
            end
        end else if (op_is_div(op_r)) begin
            result_s = quot_s;
        end else begin
            result_s = remd_s;
        end
    end

    // Registered outputs: result and done pulse on completion, busy follows next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r    <= 32'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (finish_s) begin
                c_r <= result_s;
            end
            done_r <= finish_s;
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign C    = c_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_alu_iter_divider.sv
// Self-checking bench for alu_iter_divider: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_iter_divider;
    import alu_iter_divider_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] C;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    alu_iter_divider dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alu_op (alu_op),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .C      (C),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M semantics from plain arithmetic.
    function automatic logic [31:0] ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 32'd0) ? a : a % b;
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return 32'd0;
        endcase
    endfunction

    // Drive a request so it is sampled at the next edge (edge 0); returns
    // the cycle count and busy count observed just after edge 0.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int bcnt);
        alu_op = op;
        A      = a;
        B      = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        cyc    = 1;
        bcnt   = (busy === 1'b1) ? 1 : 0;
    endtask

    task automatic tick(inout int cyc, inout int bcnt);
        @(posedge clk);
        #1;
        cyc++;
        if (busy === 1'b1) bcnt++;
    endtask

    task automatic wait_done(input int max_cyc, inout int cyc, inout int bcnt);
        while (done !== 1'b1 && cyc < max_cyc) tick(cyc, bcnt);
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int cyc;
        int bcnt;
        launch(op, a, b, cyc, bcnt);
        wait_done(60, cyc, bcnt);
        check(tag, C, exp);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dcnt;
        logic [31:0] last_c;
        logic [3:0]  ops [4];
        ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;

        // Reset state
        #12;
        check("rst_C", C, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // DIVU 100/7 with latency and busy length
        launch(OP_DIVU, 32'd100, 32'd7, cyc, bcnt);
        wait_done(60, cyc, bcnt);
        check("divu_100_7", C, 32'd14);
        check("divu_lat", 32'(cyc), 32'd34);
        check("divu_busy_cycles", 32'(bcnt), 32'd33);
        check("busy_low_with_done", {31'd0, busy}, 32'd0);

        run_check("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_check("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_check("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_check("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_check("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_check("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2);
        run_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_check("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run_check("bad_op", 4'h0, 32'd9, 32'd3, 32'd0, 2);

        // start while busy is ignored
        launch(OP_DIVU, 32'd1000, 32'd3, cyc, bcnt);
        while (cyc < 10) tick(cyc, bcnt);
        alu_op = OP_DIV;
        A      = 32'd77;
        B      = 32'd0;
        start  = 1'b1;
        tick(cyc, bcnt);
        start  = 1'b0;
        wait_done(60, cyc, bcnt);
        check("ignored_start_C", C, 32'd333);
        check("ignored_start_lat", 32'(cyc), 32'd34);
        last_c = 32'd333;
        // nothing may follow from the dropped request
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(cyc, bcnt);
            if (done === 1'b1) dcnt++;
        end
        check("ignored_start_no_extra_done", 32'(dcnt), 32'd0);

        // flush at cycle 5 of CALC
        launch(OP_DIVU, 32'd50, 32'd5, cyc, bcnt);
        while (cyc < 5) tick(cyc, bcnt);
        flush = 1'b1;
        tick(cyc, bcnt);
        flush = 1'b0;
        check("flush_busy_drop", {31'd0, busy}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(cyc, bcnt);
            if (done === 1'b1) dcnt++;
        end
        check("flush_no_done", 32'(dcnt), 32'd0);
        check("flush_C_kept", C, last_c);
        run_check("after_flush", OP_DIVU, 32'd50, 32'd5, 32'd10, 34);
        last_c = 32'd10;

        // flush together with start in IDLE drops the request
        alu_op = OP_DIVU;
        A      = 32'd9;
        B      = 32'd0;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        flush  = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(cyc, bcnt);
            if (done === 1'b1) dcnt++;
        end
        check("flush_start_no_done", 32'(dcnt), 32'd0);
        check("flush_start_C", C, last_c);

        // Reset asserted at cycle 20 of CALC acts without a clock edge
        launch(OP_DIVU, 32'd123456, 32'd7, cyc, bcnt);
        while (cyc < 20) tick(cyc, bcnt);
        rst = 1'b1;
        #2;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_C", C, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back: second start issued in the done cycle
        launch(OP_DIV, 32'hFFFF_FF9C, 32'd7, cyc, bcnt);
        wait_done(60, cyc, bcnt);
        check("b2b_first", C, 32'hFFFF_FFF2);
        launch(OP_REMU, 32'd1000, 32'd7, cyc, bcnt);
        wait_done(60, cyc, bcnt);
        check("b2b_second", C, 32'd6);
        check("b2b_second_lat", 32'(cyc), 32'd34);

        // Randomized operations against the reference model
        for (int n = 0; n < 30; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 8) op = ops[sel % 4];
            else         op = (sel == 8) ? 4'h0 : 4'hF;
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_check("rand", op, a, b, ref_calc(op, a, b),
                      (op_is_valid(op) && b != 32'd0) ? 34 : 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
